// File: rtl/dispatch_unit_if.sv
// Rename-to-dispatch packet types and the dispatch bus interface
// (rename packet, CDB snoop and the three reservation-station handshakes).
package dispatch_pkg;
    localparam int PKG_PREG_W = 6;
    localparam int PKG_ROB_W  = 6;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [PKG_PREG_W-1:0] rs1_p;
        logic [PKG_PREG_W-1:0] rs2_p;
        logic [PKG_PREG_W-1:0] rd_new_p;
        logic [PKG_PREG_W-1:0] rd_old_p;
        logic [PKG_ROB_W-1:0]  rob_tag;
        logic                  RegWrite;
        logic                  MemRead;
        logic                  ALUSrc;
        logic [3:0]            ALUOp;
        logic                  branch;
        logic                  jump;
    } ren_disp_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [PKG_PREG_W-1:0] p_src1;
        logic [PKG_PREG_W-1:0] p_src2;
        logic [PKG_PREG_W-1:0] p_dst;
        logic [PKG_ROB_W-1:0]  rob_tag;
        logic                  src1_ready;
        logic                  src2_ready;
        logic [3:0]            alu_op;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
    } rs_entry_t;
endpackage

interface dispatch_unit_if;
    import dispatch_pkg::*;

    ren_disp_t             ren_pkt;
    logic                  ren_mem_write;
    logic                  ren_ready;
    logic                  cdb_valid;
    logic [PKG_PREG_W-1:0] cdb_tag;
    rs_entry_t             out_entry;
    logic                  br_is_jump;
    logic                  alu_valid;
    logic                  alu_ready;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic                  br_valid;
    logic                  br_ready;

    modport master (
        output ren_pkt, ren_mem_write, cdb_valid, cdb_tag, alu_ready, lsu_ready, br_ready,
        input  ren_ready, out_entry, br_is_jump, alu_valid, lsu_valid, br_valid
    );

    modport slave (
        input  ren_pkt, ren_mem_write, cdb_valid, cdb_tag, alu_ready, lsu_ready, br_ready,
        output ren_ready, out_entry, br_is_jump, alu_valid, lsu_valid, br_valid
    );
endinterface

// File: rtl/dispatch_unit.sv
// Dispatch stage: one-entry holding register, CDB-snooped busy table and routing to ALU/LSU/BR
// reservation stations. Optional perf counters are built when DISPATCH_PERF_CNT_EN is defined.
module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = PKG_PREG_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
`ifdef DISPATCH_PERF_CNT_EN
    output logic [31:0] perf_disp_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    dispatch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LSU = 2'd1,
        CLS_BR  = 2'd2
    } cls_e;

    logic                 buf_valid_r;
    cls_e                 buf_cls_r;
    rs_entry_t            entry_r;
    logic                 jump_r;
    logic [NUM_PREGS-1:0] busy_r;
    logic [NUM_PREGS-1:0] busy_nxt_s;

    logic                 sel_ready_s;
    logic                 fire_s;
    logic                 ren_ready_s;
    logic                 accept_s;
    logic                 busy_set_s;
    logic [PREG_W-1:0]    rs1_s;
    logic [PREG_W-1:0]    rs2_s;
    logic [PREG_W-1:0]    rd_s;
    logic [PREG_W-1:0]    cdb_tag_s;
    cls_e                 new_cls_s;
    rs_entry_t            new_entry_s;
    logic                 unused_s;

    assign rs1_s     = bus.ren_pkt.rs1_p;
    assign rs2_s     = bus.ren_pkt.rs2_p;
    assign rd_s      = bus.ren_pkt.rd_new_p;
    assign cdb_tag_s = bus.cdb_tag;
    assign unused_s  = ^bus.ren_pkt.rd_old_p;

    // Ready of the reservation station the held packet is routed to
    always_comb begin
        sel_ready_s = 1'b0;
        case (buf_cls_r)
            CLS_ALU: sel_ready_s = bus.alu_ready;
            CLS_LSU: sel_ready_s = bus.lsu_ready;
            CLS_BR:  sel_ready_s = bus.br_ready;
            default: sel_ready_s = 1'b0;
        endcase
    end

    assign fire_s      = buf_valid_r && !flush && sel_ready_s;
    assign ren_ready_s = rst_n && !flush && (!buf_valid_r || fire_s);
    assign accept_s    = bus.ren_pkt.valid && ren_ready_s;
    assign busy_set_s  = accept_s && bus.ren_pkt.RegWrite && (|rd_s);

    assign bus.ren_ready  = ren_ready_s;
    assign bus.out_entry  = entry_r;
    assign bus.br_is_jump = jump_r;
    assign bus.alu_valid  = buf_valid_r && !flush && (buf_cls_r == CLS_ALU);
    assign bus.lsu_valid  = buf_valid_r && !flush && (buf_cls_r == CLS_LSU);
    assign bus.br_valid   = buf_valid_r && !flush && (buf_cls_r == CLS_BR);

    // Convert the incoming rename packet; a same-cycle CDB hit counts as ready
    always_comb begin
        new_entry_s            = '0;
        new_entry_s.pc         = bus.ren_pkt.pc;
        new_entry_s.imm        = bus.ren_pkt.imm;
        new_entry_s.p_src1     = rs1_s;
        new_entry_s.p_src2     = rs2_s;
        new_entry_s.p_dst      = rd_s;
        new_entry_s.rob_tag    = bus.ren_pkt.rob_tag;
        new_entry_s.alu_op     = bus.ren_pkt.ALUOp;
        new_entry_s.alu_src    = bus.ren_pkt.ALUSrc;
        new_entry_s.mem_read   = bus.ren_pkt.MemRead;
        new_entry_s.mem_write  = bus.ren_mem_write;
        new_entry_s.src1_ready = !(|rs1_s) || !busy_r[rs1_s] || (bus.cdb_valid && (cdb_tag_s == rs1_s));
        new_entry_s.src2_ready = !(|rs2_s) || !busy_r[rs2_s] || (bus.cdb_valid && (cdb_tag_s == rs2_s))
                                 || bus.ren_pkt.ALUSrc;
        if (bus.ren_pkt.branch || bus.ren_pkt.jump) begin
            new_cls_s = CLS_BR;
        end else if (bus.ren_pkt.MemRead || bus.ren_mem_write) begin
            new_cls_s = CLS_LSU;
        end else begin
            new_cls_s = CLS_ALU;
        end
    end

    // Busy table next state: a set on the same tag as a CDB clear wins
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NUM_PREGS; i++) begin
            busy_nxt_s[i] = (busy_set_s && (rd_s == PREG_W'(i)))
                            || (busy_r[i] && !(bus.cdb_valid && (cdb_tag_s == PREG_W'(i))));
        end
    end

    // Holding register and busy table; flush drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_r <= 1'b0;
            buf_cls_r   <= CLS_ALU;
            entry_r     <= '0;
            jump_r      <= 1'b0;
            busy_r      <= '0;
        end else if (flush) begin
            buf_valid_r <= 1'b0;
            busy_r      <= '0;
        end else begin
            busy_r <= busy_nxt_s;
            if (accept_s) begin
                buf_valid_r <= 1'b1;
                buf_cls_r   <= new_cls_s;
                entry_r     <= new_entry_s;
                jump_r      <= bus.ren_pkt.jump;
            end else if (fire_s) begin
                buf_valid_r <= 1'b0;
            end else begin
                if (bus.cdb_valid && (cdb_tag_s == entry_r.p_src1)) begin
                    entry_r.src1_ready <= 1'b1;
                end
                if (bus.cdb_valid && (cdb_tag_s == entry_r.p_src2)) begin
                    entry_r.src2_ready <= 1'b1;
                end
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    // Perf counters survive flush; only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_disp_cnt  <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (fire_s) begin
                perf_disp_cnt <= perf_disp_cnt + 32'd1;
            end
            if (buf_valid_r && !fire_s && !flush) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: routing table plus hand sequences for
// dependence, bypass, stall, flush and mid-stall reset, checked against a scoreboard model.
module tb_dispatch_unit;
    import dispatch_pkg::*;

    typedef struct {
        ren_disp_t   pkt;
        logic        mw;
        logic        cdbv;
        logic [5:0]  cdbt;
        logic [2:0]  rdy;
        logic        fl;
        logic [2:0]  exp_v;
    } vec_t;

    typedef struct {
        rs_entry_t   e;
        logic [2:0]  vmask;
        logic        jmp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    dispatch_unit_if ifc();

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] perf_disp_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    dispatch_unit #(.NUM_PREGS(64), .PREG_W(6)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
`ifdef DISPATCH_PERF_CNT_EN
        .perf_disp_cnt  (perf_disp_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .bus            (ifc)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [63:0] m_busy = 64'd0;
    ren_disp_t   idle = '0;
    vec_t        tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ren_disp_t mk(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                                     input logic rw, input logic mr, input logic asrc,
                                     input logic br, input logic jmp, input logic [3:0] op,
                                     input logic [31:0] pc);
        ren_disp_t p;
        p          = '0;
        p.valid    = 1'b1;
        p.pc       = pc;
        p.imm      = pc ^ 32'h5a5a_0000;
        p.rs1_p    = rs1;
        p.rs2_p    = rs2;
        p.rd_new_p = rd;
        p.rd_old_p = rd ^ 6'h15;
        p.rob_tag  = pc[7:2];
        p.RegWrite = rw;
        p.MemRead  = mr;
        p.ALUSrc   = asrc;
        p.ALUOp    = op;
        p.branch   = br;
        p.jump     = jmp;
        return p;
    endfunction

    // One clock: drive at negedge, check against the model, then advance the model to the next edge
    task automatic cycle(input ren_disp_t p, input logic mw, input logic cdbv, input logic [5:0] cdbt,
                         input logic [2:0] rdy, input logic fl);
        logic       held;
        logic       exp_fire;
        logic       exp_rr;
        logic       acc;
        logic [2:0] exp_v;
        exp_t       ent;
        exp_t       ne;
        @(negedge clk);
        ifc.ren_pkt       = p;
        ifc.ren_mem_write = mw;
        ifc.cdb_valid     = cdbv;
        ifc.cdb_tag       = cdbt;
        ifc.alu_ready     = rdy[2];
        ifc.lsu_ready     = rdy[1];
        ifc.br_ready      = rdy[0];
        flush             = fl;
        #1;
        held     = (sb.size() != 0);
        exp_fire = 1'b0;
        exp_v    = 3'b000;
        ent      = '{e: '0, vmask: 3'b000, jmp: 1'b0};
        if (held) begin
            ent = sb[0];
            if (!fl) begin
                exp_v    = ent.vmask;
                exp_fire = |(ent.vmask & rdy);
            end
        end
        exp_rr = !fl && (!held || exp_fire);
        chk("valids", 128'({ifc.alu_valid, ifc.lsu_valid, ifc.br_valid}), 128'(exp_v));
        chk("ren_ready", 128'(ifc.ren_ready), 128'(exp_rr));
        if (held && !fl) begin
            chk("out_entry", 128'(ifc.out_entry), 128'(ent.e));
            chk("br_is_jump", 128'(ifc.br_is_jump), 128'(ent.jmp));
        end
        acc = p.valid && exp_rr;
        if (fl) begin
            sb.delete();
            m_busy = 64'd0;
        end else begin
            if (exp_fire) begin
                void'(sb.pop_front());
            end else if (held && cdbv) begin
                if (cdbt == ent.e.p_src1) ent.e.src1_ready = 1'b1;
                if (cdbt == ent.e.p_src2) ent.e.src2_ready = 1'b1;
                sb[0] = ent;
            end
            if (acc) begin
                ne.e            = '0;
                ne.e.pc         = p.pc;
                ne.e.imm        = p.imm;
                ne.e.p_src1     = p.rs1_p;
                ne.e.p_src2     = p.rs2_p;
                ne.e.p_dst      = p.rd_new_p;
                ne.e.rob_tag    = p.rob_tag;
                ne.e.alu_op     = p.ALUOp;
                ne.e.alu_src    = p.ALUSrc;
                ne.e.mem_read   = p.MemRead;
                ne.e.mem_write  = mw;
                ne.e.src1_ready = (p.rs1_p == 6'd0) || !m_busy[p.rs1_p] || (cdbv && cdbt == p.rs1_p);
                ne.e.src2_ready = (p.rs2_p == 6'd0) || !m_busy[p.rs2_p] || (cdbv && cdbt == p.rs2_p) || p.ALUSrc;
                ne.vmask        = (p.branch || p.jump) ? 3'b001 : ((p.MemRead || mw) ? 3'b010 : 3'b100);
                ne.jmp          = p.jump;
                sb.push_back(ne);
            end
            if (cdbv) m_busy[cdbt] = 1'b0;
            if (acc && p.RegWrite && p.rd_new_p != 6'd0) m_busy[p.rd_new_p] = 1'b1;
        end
    endtask

    initial begin
`ifdef DISPATCH_PERF_CNT_EN
        logic [31:0] st0;
        logic [31:0] d0;
`endif
        tbl[0] = '{mk(6'd1, 6'd2, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 32'h100), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0, 3'b000};
        tbl[1] = '{mk(6'd40, 6'd9, 6'd33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h104), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0, 3'b100};
        tbl[2] = '{mk(6'd5, 6'd6, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 32'h108), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0, 3'b010};
        tbl[3] = '{mk(6'd3, 6'd33, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h10c), 1'b1, 1'b0, 6'd0, 3'b111, 1'b0, 3'b001};
        tbl[4] = '{mk(6'd7, 6'd0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h110), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0, 3'b010};
        tbl[5] = '{idle, 1'b0, 1'b1, 6'd40, 3'b111, 1'b0, 3'b001};
        tbl[6] = '{idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0, 3'b000};

        rst_n = 1'b0;
        flush = 1'b0;
        ifc.ren_pkt = idle;
        ifc.ren_mem_write = 1'b0;
        ifc.cdb_valid = 1'b0;
        ifc.cdb_tag = 6'd0;
        ifc.alu_ready = 1'b1;
        ifc.lsu_ready = 1'b1;
        ifc.br_ready = 1'b1;
        #2;
        chk("rst_ren_ready", 128'(ifc.ren_ready), 128'(1'b0));
        chk("rst_valids", 128'({ifc.alu_valid, ifc.lsu_valid, ifc.br_valid}), 128'(3'b000));
        chk("rst_out_entry", 128'(ifc.out_entry), 128'd0);
        chk("rst_br_is_jump", 128'(ifc.br_is_jump), 128'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Routing table
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].pkt, tbl[i].mw, tbl[i].cdbv, tbl[i].cdbt, tbl[i].rdy, tbl[i].fl);
            chk("tbl_valids", 128'({ifc.alu_valid, ifc.lsu_valid, ifc.br_valid}), 128'(tbl[i].exp_v));
            if (i == 2) chk("busy40_seen", 128'(ifc.out_entry.src1_ready), 128'(1'b0));
        end

        // Dependence and snoop while held
        cycle(mk(6'd1, 6'd2, 6'd45, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 32'h200), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(mk(6'd45, 6'd3, 6'd46, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 32'h204), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(idle, 1'b0, 1'b1, 6'd45, 3'b011, 1'b0);
        chk("dep_src1_low", 128'(ifc.out_entry.src1_ready), 128'(1'b0));
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b011, 1'b0);
        chk("dep_src1_snoop", 128'(ifc.out_entry.src1_ready), 128'(1'b1));
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);

        // Same-cycle bypass
        cycle(mk(6'd1, 6'd2, 6'd41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 32'h300), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(mk(6'd4, 6'd41, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 32'h304), 1'b0, 1'b1, 6'd41, 3'b111, 1'b0);
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b011, 1'b0);
        chk("bypass_src2", 128'(ifc.out_entry.src2_ready), 128'(1'b1));
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);

        // Stall and stability
        cycle(mk(6'd8, 6'd9, 6'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h400), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
`ifdef DISPATCH_PERF_CNT_EN
        st0 = perf_stall_cnt;
        d0  = perf_disp_cnt;
`endif
        for (int k = 0; k < 5; k++) begin
            cycle(mk(6'd1, 6'd2, 6'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 32'h404), 1'b0, 1'b0, 6'd0, 3'b101, 1'b0);
            chk("stall_ren_ready", 128'(ifc.ren_ready), 128'(1'b0));
        end
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
`ifdef DISPATCH_PERF_CNT_EN
        chk("perf_stall", 128'(perf_stall_cnt - st0), 128'(32'd5));
        chk("perf_disp", 128'(perf_disp_cnt - d0), 128'(32'd1));
`endif

        // Flush with busy 33/40 set and a held packet
        cycle(mk(6'd1, 6'd2, 6'd33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 32'h500), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(mk(6'd3, 6'd4, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 32'h504), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b011, 1'b0);
        cycle(mk(6'd5, 6'd6, 6'd50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 32'h508), 1'b0, 1'b1, 6'd33, 3'b111, 1'b1);
        chk("flush_valids", 128'({ifc.alu_valid, ifc.lsu_valid, ifc.br_valid}), 128'(3'b000));
        chk("flush_ren_ready", 128'(ifc.ren_ready), 128'(1'b0));
        cycle(mk(6'd33, 6'd40, 6'd51, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 32'h50c), 1'b0, 1'b0, 6'd0, 3'b011, 1'b0);
        chk("postflush_ready", 128'(ifc.ren_ready), 128'(1'b1));
        chk("postflush_valids", 128'({ifc.alu_valid, ifc.lsu_valid, ifc.br_valid}), 128'(3'b000));
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b011, 1'b0);
        chk("postflush_busy", 128'({ifc.out_entry.src1_ready, ifc.out_entry.src2_ready}), 128'(2'b11));
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);

        // Reset asserted while a load is stalled
        cycle(mk(6'd1, 6'd2, 6'd20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h600), 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b101, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valids", 128'({ifc.alu_valid, ifc.lsu_valid, ifc.br_valid}), 128'(3'b000));
        chk("midrst_ren_ready", 128'(ifc.ren_ready), 128'(1'b0));
        chk("midrst_out_entry", 128'(ifc.out_entry), 128'd0);
        sb.delete();
        m_busy = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(mk(6'd20, 6'd3, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 32'h604), 1'b0, 1'b0, 6'd0, 3'b011, 1'b0);
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b011, 1'b0);
        chk("rst_busy_clear", 128'(ifc.out_entry.src1_ready), 128'(1'b1));
        cycle(idle, 1'b0, 1'b0, 6'd0, 3'b111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
